eval_arbiter: RTL

//  Shares one pipelined evaluate instance among NUM_REQ board producers (move-gen/search lanes).

---
 rtl/eval_arbiter_pkg.sv | 17 +
 rtl/eval_arbiter_if.sv | 43 ++++
 rtl/eval_tag_fifo.sv | 48 ++++
 rtl/eval_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/eval_arbiter_pkg.sv
// Shared constants and payload types for the evaluate arbiter slice.
package eval_arbiter_pkg;

  localparam int unsigned PIECE_WIDTH  = 4;
  localparam int unsigned BOARD_WIDTH  = PIECE_WIDTH * 64;
  localparam int unsigned EVAL_WIDTH   = 22;
  localparam int unsigned CASTLE_WIDTH = 4;
  localparam int unsigned EP_WIDTH     = 4;

  typedef struct packed {
    logic [BOARD_WIDTH-1:0]  board;
    logic                    white_to_move;
    logic [CASTLE_WIDTH-1:0] castle_mask;
    logic [EP_WIDTH-1:0]     en_passant_col;
  } board_req_t;

endpackage

// File: rtl/eval_arbiter_if.sv
// Requester, evaluate and response signals of the evaluate arbiter.
interface eval_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import eval_arbiter_pkg::*;

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*BOARD_WIDTH-1:0]  req_board;
  logic [NUM_REQ-1:0]              req_white_to_move;
  logic [NUM_REQ*CASTLE_WIDTH-1:0] req_castle_mask;
  logic [NUM_REQ*EP_WIDTH-1:0]     req_en_passant_col;

  logic                            eval_board_valid;
  logic [BOARD_WIDTH-1:0]          eval_board;
  logic                            eval_white_to_move;
  logic [CASTLE_WIDTH-1:0]         eval_castle_mask;
  logic [EP_WIDTH-1:0]             eval_en_passant_col;
  logic signed [EVAL_WIDTH-1:0]    eval_in;
  logic                            eval_valid_in;

  logic [NUM_REQ-1:0]              rsp_valid;
  logic signed [EVAL_WIDTH-1:0]    rsp_eval;
  logic                            busy;
  logic                            err_unexpected;

  // Environment side: requesters plus the evaluate pipeline.
  modport master (
    output req_valid, req_board, req_white_to_move, req_castle_mask, req_en_passant_col,
    output eval_in, eval_valid_in,
    input  req_ready, eval_board_valid, eval_board, eval_white_to_move,
    input  eval_castle_mask, eval_en_passant_col, rsp_valid, rsp_eval, busy, err_unexpected
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_board, req_white_to_move, req_castle_mask, req_en_passant_col,
    input  eval_in, eval_valid_in,
    output req_ready, eval_board_valid, eval_board, eval_white_to_move,
    output eval_castle_mask, eval_en_passant_col, rsp_valid, rsp_eval, busy, err_unexpected
  );

endinterface

// File: rtl/eval_tag_fifo.sv
// Synchronous FIFO of requester tags for boards in flight inside evaluate.
module eval_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_tag,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_tag,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_q;

  assign count   = count_q;
  assign empty   = (count_q == '0);
  // An empty FIFO forwards the incoming tag so a same-cycle push/pop stays consistent.
  assign pop_tag = empty ? push_tag : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/eval_arbiter.sv
// Round-robin sharing of one pipelined evaluate among NUM_REQ board producers,
// with in-order routing of results back to the issuing requester.
module eval_arbiter
  import eval_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input logic          clk,
  input logic          reset,
  eval_arbiter_if.slave bus
);
  localparam int unsigned TAG_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [TAG_W-1:0]             ptr;
  logic [TAG_W-1:0]             grant_idx;
  logic [TAG_W-1:0]             next_ptr;
  logic [TAG_W-1:0]             pop_tag;
  logic [NUM_REQ-1:0]           ready_c;
  logic                         push;
  logic                         pop;
  logic                         unexpected;
  logic                         can_issue;
  logic                         fifo_empty;
  logic [CNT_W-1:0]             count;
  board_req_t                   sel;
  board_req_t                   issue_q;
  logic                         issue_valid_q;
  logic [NUM_REQ-1:0]           rsp_valid_q;
  logic signed [EVAL_WIDTH-1:0] rsp_eval_q;
  logic                         err_q;

  // Credit check uses the registered count only; a same-cycle pop frees nothing yet.
  assign can_issue = (count < CNT_W'(MAX_OUTSTANDING));

  always_comb begin : grant_search
    logic [TAG_W-1:0] idx;
    ready_c   = '0;
    grant_idx = '0;
    push      = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = TAG_W'((32'(ptr) + k) % NUM_REQ);
      if (can_issue && !push && bus.req_valid[idx]) begin
        push         = 1'b1;
        grant_idx    = idx;
        ready_c[idx] = 1'b1;
      end
    end
  end

  always_comb begin : payload_mux
    sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TAG_W'(i)) begin
        sel.board          = bus.req_board[i*BOARD_WIDTH +: BOARD_WIDTH];
        sel.white_to_move  = bus.req_white_to_move[i];
        sel.castle_mask    = bus.req_castle_mask[i*CASTLE_WIDTH +: CASTLE_WIDTH];
        sel.en_passant_col = bus.req_en_passant_col[i*EP_WIDTH +: EP_WIDTH];
      end
    end
  end

  assign next_ptr   = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
  assign pop        = bus.eval_valid_in & (~fifo_empty | push);
  assign unexpected = bus.eval_valid_in & fifo_empty & ~push;

  eval_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_tag (grant_idx),
    .pop      (pop),
    .pop_tag  (pop_tag),
    .count    (count),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr           <= '0;
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
      rsp_valid_q   <= '0;
      rsp_eval_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      issue_valid_q <= push;
      if (push) begin
        issue_q <= sel;
        ptr     <= next_ptr;
      end
      rsp_valid_q <= pop ? (NUM_REQ'(1) << pop_tag) : '0;
      if (pop)        rsp_eval_q <= bus.eval_in;
      if (unexpected) err_q      <= 1'b1;
    end
  end

  assign bus.req_ready           = ready_c;
  assign bus.eval_board_valid    = issue_valid_q;
  assign bus.eval_board          = issue_q.board;
  assign bus.eval_white_to_move  = issue_q.white_to_move;
  assign bus.eval_castle_mask    = issue_q.castle_mask;
  assign bus.eval_en_passant_col = issue_q.en_passant_col;
  assign bus.rsp_valid           = rsp_valid_q;
  assign bus.rsp_eval            = rsp_eval_q;
  assign bus.busy                = (count != '0) | issue_valid_q;
  assign bus.err_unexpected      = err_q;

endmodule
